// File: rtl/ctrl_rx_gen_if.sv
// Bundle between the received-word source / result path and the ctrl_rx_gen
// command decoder; master is the word source side, slave is the decoder.
interface ctrl_rx_gen_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int FUN_W  = 4
) ();
  logic [DATA_W-1:0] RX_P_DATA;
  logic              RX_D_Valid;
  logic              Busy;
  logic              ALU_EN;
  logic [FUN_W-1:0]  ALU_FUN;
  logic              CLK_G_EN;
  logic              WrEn;
  logic              RdEn;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] WrData;
  logic              Cmd_Err;
  logic              Frame_Busy;

  modport master (
    output RX_P_DATA, RX_D_Valid, Busy,
    input  ALU_EN, ALU_FUN, CLK_G_EN, WrEn, RdEn, Addr, WrData, Cmd_Err, Frame_Busy
  );

  modport slave (
    input  RX_P_DATA, RX_D_Valid, Busy,
    output ALU_EN, ALU_FUN, CLK_G_EN, WrEn, RdEn, Addr, WrData, Cmd_Err, Frame_Busy
  );
endinterface

// File: rtl/ctrl_rx_gen.sv
// Frame decoder for received command words: drives register writes/reads and
// ALU starts, aborting frames that stall longer than TO_CYC idle cycles.
module ctrl_rx_gen #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int FUN_W  = 4,
  parameter int TO_W   = 8,
  parameter int TO_CYC = 200
) (
  input logic          CLK,
  input logic          RST,
  ctrl_rx_gen_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_ADDR  = 3'd1,
    WR_DATA  = 3'd2,
    RD_ADDR  = 3'd3,
    ALU_A    = 3'd4,
    ALU_B    = 3'd5,
    ALU_FUN  = 3'd6,
    ALU_WAIT = 3'd7
  } state_t;

  localparam logic [7:0]        OP_WR    = 8'hAA;
  localparam logic [7:0]        OP_RD    = 8'hBB;
  localparam logic [7:0]        OP_ALU   = 8'hCC;
  localparam logic [7:0]        OP_ALU_N = 8'hDD;
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TO_CYC - 1);
  localparam logic [TO_W-1:0]   TO_ONE   = {{(TO_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_r, state_nx_s;
  logic [ADDR_W-1:0] addr_lat_r, addr_lat_nx_s;
  logic [FUN_W-1:0]  fun_lat_r, fun_lat_nx_s;
  logic [TO_W-1:0]   to_cnt_r, to_cnt_nx_s;

  logic              wr_en_s, rd_en_s, alu_en_s, cmd_err_s;
  logic [ADDR_W-1:0] addr_s;
  logic [DATA_W-1:0] wr_data_s;
  logic [FUN_W-1:0]  alu_fun_s;
  logic              clk_g_en_s;

  logic              wr_en_r, rd_en_r, alu_en_r, cmd_err_r, clk_g_en_r, frame_busy_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wr_data_r;
  logic [FUN_W-1:0]  alu_fun_r;

  logic              valid_s, in_frame_s, timeout_s;
  logic [7:0]        rx_byte_s;

  assign valid_s    = bus.RX_D_Valid;
  assign rx_byte_s  = bus.RX_P_DATA[7:0];
  // ALU_WAIT is exempt from the idle timeout; it only waits on Busy.
  assign in_frame_s = (state_r != IDLE) && (state_r != ALU_WAIT);
  assign timeout_s  = in_frame_s && !valid_s && (to_cnt_r == TO_LAST);

  // Idle-cycle counter next value, saturating.
  always_comb begin
    to_cnt_nx_s = to_cnt_r;
    if (!in_frame_s || valid_s || timeout_s) begin
      to_cnt_nx_s = '0;
    end else if (to_cnt_r != {TO_W{1'b1}}) begin
      to_cnt_nx_s = to_cnt_r + TO_ONE;
    end else begin
      to_cnt_nx_s = to_cnt_r;
    end
  end

  // Frame FSM next state and next values of the registered outputs.
  always_comb begin
    state_nx_s    = state_r;
    addr_lat_nx_s = addr_lat_r;
    fun_lat_nx_s  = fun_lat_r;
    wr_en_s       = 1'b0;
    rd_en_s       = 1'b0;
    alu_en_s      = 1'b0;
    cmd_err_s     = 1'b0;
    addr_s        = '0;
    wr_data_s     = '0;
    alu_fun_s     = '0;
    case (state_r)
      IDLE: begin
        if (valid_s) begin
          case (rx_byte_s)
            OP_WR:    state_nx_s = WR_ADDR;
            OP_RD:    state_nx_s = RD_ADDR;
            OP_ALU:   state_nx_s = ALU_A;
            OP_ALU_N: state_nx_s = ALU_FUN;
            default:  cmd_err_s  = 1'b1;
          endcase
        end else begin
          state_nx_s = IDLE;
        end
      end
      WR_ADDR: begin
        if (valid_s) begin
          addr_lat_nx_s = bus.RX_P_DATA[ADDR_W-1:0];
          state_nx_s    = WR_DATA;
        end else if (timeout_s) begin
          cmd_err_s  = 1'b1;
          state_nx_s = IDLE;
        end else begin
          state_nx_s = WR_ADDR;
        end
      end
      WR_DATA: begin
        if (valid_s) begin
          wr_en_s    = 1'b1;
          addr_s     = addr_lat_r;
          wr_data_s  = bus.RX_P_DATA;
          state_nx_s = IDLE;
        end else if (timeout_s) begin
          cmd_err_s  = 1'b1;
          state_nx_s = IDLE;
        end else begin
          state_nx_s = WR_DATA;
        end
      end
      RD_ADDR: begin
        if (valid_s) begin
          rd_en_s    = 1'b1;
          addr_s     = bus.RX_P_DATA[ADDR_W-1:0];
          state_nx_s = IDLE;
        end else if (timeout_s) begin
          cmd_err_s  = 1'b1;
          state_nx_s = IDLE;
        end else begin
          state_nx_s = RD_ADDR;
        end
      end
      ALU_A: begin
        if (valid_s) begin
          wr_en_s    = 1'b1;
          addr_s     = '0;
          wr_data_s  = bus.RX_P_DATA;
          state_nx_s = ALU_B;
        end else if (timeout_s) begin
          cmd_err_s  = 1'b1;
          state_nx_s = IDLE;
        end else begin
          state_nx_s = ALU_A;
        end
      end
      ALU_B: begin
        if (valid_s) begin
          wr_en_s    = 1'b1;
          addr_s     = ADDR_ONE;
          wr_data_s  = bus.RX_P_DATA;
          state_nx_s = ALU_FUN;
        end else if (timeout_s) begin
          cmd_err_s  = 1'b1;
          state_nx_s = IDLE;
        end else begin
          state_nx_s = ALU_B;
        end
      end
      ALU_FUN: begin
        if (valid_s) begin
          fun_lat_nx_s = bus.RX_P_DATA[FUN_W-1:0];
          if (!bus.Busy) begin
            alu_en_s   = 1'b1;
            alu_fun_s  = bus.RX_P_DATA[FUN_W-1:0];
            state_nx_s = IDLE;
          end else begin
            state_nx_s = ALU_WAIT;
          end
        end else if (timeout_s) begin
          cmd_err_s  = 1'b1;
          state_nx_s = IDLE;
        end else begin
          state_nx_s = ALU_FUN;
        end
      end
      ALU_WAIT: begin
        // A word arriving here is dropped but flagged; release still follows Busy.
        if (valid_s) begin
          cmd_err_s = 1'b1;
        end else begin
          cmd_err_s = 1'b0;
        end
        if (!bus.Busy) begin
          alu_en_s   = 1'b1;
          alu_fun_s  = fun_lat_r;
          state_nx_s = IDLE;
        end else begin
          state_nx_s = ALU_WAIT;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Gate enable covers the ALU frame states plus the start pulse cycle.
  always_comb begin
    clk_g_en_s = alu_en_s;
    case (state_nx_s)
      ALU_A, ALU_B, ALU_FUN, ALU_WAIT: clk_g_en_s = 1'b1;
      default:                         clk_g_en_s = alu_en_s;
    endcase
  end

  // State, latches, counter and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r      <= IDLE;
      addr_lat_r   <= '0;
      fun_lat_r    <= '0;
      to_cnt_r     <= '0;
      wr_en_r      <= 1'b0;
      rd_en_r      <= 1'b0;
      alu_en_r     <= 1'b0;
      cmd_err_r    <= 1'b0;
      clk_g_en_r   <= 1'b0;
      frame_busy_r <= 1'b0;
      addr_r       <= '0;
      wr_data_r    <= '0;
      alu_fun_r    <= '0;
    end else begin
      state_r      <= state_nx_s;
      addr_lat_r   <= addr_lat_nx_s;
      fun_lat_r    <= fun_lat_nx_s;
      to_cnt_r     <= to_cnt_nx_s;
      wr_en_r      <= wr_en_s;
      rd_en_r      <= rd_en_s;
      alu_en_r     <= alu_en_s;
      cmd_err_r    <= cmd_err_s;
      clk_g_en_r   <= clk_g_en_s;
      frame_busy_r <= (state_nx_s != IDLE);
      addr_r       <= addr_s;
      wr_data_r    <= wr_data_s;
      alu_fun_r    <= alu_fun_s;
    end
  end

  assign bus.WrEn       = wr_en_r;
  assign bus.RdEn       = rd_en_r;
  assign bus.ALU_EN     = alu_en_r;
  assign bus.Cmd_Err    = cmd_err_r;
  assign bus.CLK_G_EN   = clk_g_en_r;
  assign bus.Frame_Busy = frame_busy_r;
  assign bus.Addr       = addr_r;
  assign bus.WrData     = wr_data_r;
  assign bus.ALU_FUN    = alu_fun_r;

endmodule

// File: doc/ctrl_rx_gen.md
CTRL_RX_GEN -- requirements
Module: ctrl_rx_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_W, 8, received byte and register write data width; must be >= 8.
- ADDR_W, 4, register-file address width.
- FUN_W, 4, ALU function code width.
- TO_W, 8, timeout counter width.
- TO_CYC, 200, number of idle cycles inside an open frame that aborts it.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- CLK, in, 1: system clock.
- RST, in, 1: synchronous active-low reset.
- RX_P_DATA, in, DATA_W: received parallel word.
- RX_D_Valid, in, 1: RX_P_DATA is valid this cycle; one word is accepted per high cycle.
- Busy, in, 1: result path is busy; the ALU must not be started.
- ALU_EN, out, 1: ALU start pulse.
- ALU_FUN, out, FUN_W: ALU function code.
- CLK_G_EN, out, 1: ALU clock-gate enable.
- WrEn, out, 1: register write pulse.
- RdEn, out, 1: register read pulse.
- Addr, out, ADDR_W: register address.
- WrData, out, DATA_W: register write data.
- Cmd_Err, out, 1: one-cycle error pulse.
- Frame_Busy, out, 1: a frame is open.

REQ-003 There SHALL be one clock, CLK; reset RST SHALL be synchronous and active-low.

Function
REQ-004 All outputs SHALL be registered; every action SHALL appear in the cycle after the clock edge that accepts the triggering word.
REQ-005 Opcodes SHALL be decoded on RX_P_DATA[7:0] only, with upper bits ignored: 0xAA = write, 0xBB = read, 0xCC = ALU with operands, 0xDD = ALU without operands.
REQ-006 FSM states SHALL be IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN, ALU_WAIT.
REQ-007 IDLE SHALL go to WR_ADDR, RD_ADDR, ALU_A or ALU_FUN on opcode 0xAA, 0xBB, 0xCC or 0xDD respectively; any other accepted word SHALL pulse Cmd_Err and stay in IDLE.
REQ-008 In WR_ADDR, the accepted word SHALL latch address RX_P_DATA[ADDR_W-1:0] and the FSM SHALL go to WR_DATA.
REQ-009 In WR_DATA, the accepted word SHALL produce a one-cycle WrEn with Addr = latched address and WrData = RX_P_DATA, then the FSM SHALL return to IDLE.
REQ-010 In RD_ADDR, the accepted word SHALL produce a one-cycle RdEn with Addr = RX_P_DATA[ADDR_W-1:0], then the FSM SHALL return to IDLE.
REQ-011 In ALU_A, the accepted word SHALL produce a one-cycle WrEn with Addr = 0 and WrData = word, then the FSM SHALL go to ALU_B.
REQ-012 In ALU_B, the accepted word SHALL produce a one-cycle WrEn with Addr = 1 and WrData = word, then the FSM SHALL go to ALU_FUN.
REQ-013 In ALU_FUN, the accepted word SHALL latch RX_P_DATA[FUN_W-1:0] as the function code.
- If Busy = 0, ALU_EN SHALL pulse for one cycle with ALU_FUN = code, and the FSM SHALL go to IDLE.
- If Busy = 1, the FSM SHALL go to ALU_WAIT.
REQ-014 ALU_WAIT SHALL hold until the first cycle with Busy = 0, then pulse ALU_EN with the held ALU_FUN and go to IDLE; no timeout SHALL apply in this state.
REQ-015 A word accepted in ALU_WAIT SHALL be dropped, SHALL pulse Cmd_Err, and SHALL NOT change state.
REQ-016 CLK_G_EN SHALL be high while the state is ALU_A, ALU_B, ALU_FUN or ALU_WAIT, and during the ALU_EN cycle; it SHALL be low otherwise.
REQ-017 ALU_FUN, Addr and WrData SHALL be 0 whenever their qualifying strobe (ALU_EN, WrEn/RdEn, WrEn respectively) is low.
REQ-018 Timeout counter behaviour:
- The counter SHALL clear on every accepted word and whenever the state is IDLE or ALU_WAIT.
- It SHALL increment on each cycle without RX_D_Valid in any other state, saturating at 2^TO_W-1.
- When the count reaches TO_CYC, Cmd_Err SHALL pulse, the FSM SHALL go to IDLE, and no strobe SHALL be issued for the partial frame.
REQ-019 If RX_D_Valid coincides with the timeout cycle, the word SHALL be processed normally and the timeout SHALL be ignored.
REQ-020 Frame_Busy SHALL be high whenever the state is not IDLE.

Reset
REQ-021 With RST = 0 at a CLK edge, the FSM SHALL enter IDLE, all outputs, latches and the counter SHALL clear to 0, and any open frame SHALL be discarded without any strobe.
REQ-022 A reset asserted mid-frame SHALL NOT produce partial WrEn, RdEn or ALU_EN pulses on the edges that follow.

Verification
REQ-023 Words AA, 05, 3C -> single WrEn, Addr = 5, WrData = 0x3C, one cycle after the 3C word.
REQ-024 Words BB, 0A -> single RdEn, Addr = 0xA, with WrEn = 0 throughout.
REQ-025 Words CC, 12, 34, 02 with Busy = 0 -> WrEn at Addr 0 with data 0x12, WrEn at Addr 1 with data 0x34, ALU_EN with ALU_FUN = 2; CLK_G_EN high from after CC through the ALU_EN cycle.
REQ-026 Words DD, 07 with Busy = 1 for 10 cycles -> no ALU_EN for 10 cycles, then ALU_EN with ALU_FUN = 7 in the first Busy = 0 cycle; a word injected during the wait gives Cmd_Err.
REQ-027 Words AA, 03 then 200 idle cycles -> Cmd_Err pulse, return to IDLE, no WrEn; a following 0x55 word gives Cmd_Err.
REQ-028 RST low for one edge after CC, 12 -> all outputs 0, next ALU_EN never seen; a following AA, 01, FF performs a normal write.
